// File: rtl/sbox_pkg.sv
// Shared definitions for the switch-box link blocks.
package sbox_pkg;

  // Switch-box port width.
  localparam int unsigned SBOX_W = 32;

  // Side of the switch box an instance feeds; used only for instance labelling.
  typedef enum logic [1:0] {
    NORTH,
    WEST,
    SOUTH,
    EAST
  } sbox_dir_e;

  // Bits needed to hold a credit count in the range 0..credits.
  function automatic int unsigned credit_cnt_w(input int unsigned credits);
    return $clog2(credits + 1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and synchronous active-high reset.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int unsigned W     = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + AW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/sbox_link_tx.sv
// Credit-based transmitter feeding one switch-box input from a compute unit.
// Producer words are buffered in a FIFO and launched only while downstream credits remain.
module sbox_link_tx
  import sbox_pkg::*;
#(
  parameter int unsigned W       = SBOX_W,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid_i,
  input  logic [W-1:0]                        in_data_i,
  output logic                                in_ready_o,
  output logic                                out_valid_o,
  output logic [W-1:0]                        out_data_o,
  input  logic                                credit_in_i,
  output logic [credit_cnt_w(CREDITS)-1:0]    credit_cnt_o,
  output logic                                err_credit_ovf_o
);

  localparam int unsigned CW = credit_cnt_w(CREDITS);
  localparam int unsigned FW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CreditMax = CW'(CREDITS);
  localparam logic [FW-1:0] FifoMax   = FW'(DEPTH);

  logic [W-1:0]  fifo_head;
  logic [FW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          unused_fifo_full;
  logic          push;
  logic          send;

  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;
  logic          out_valid_q;
  logic [W-1:0]  out_data_q, out_data_d;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign in_ready_o       = (fifo_count < FifoMax);
  assign push             = in_valid_i && in_ready_o;
  assign send             = !fifo_empty && (credit_q != '0);
  assign unused_fifo_full = fifo_full;

  sync_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (in_data_i),
    .pop_i   (send),
    .rdata_o (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Credit accounting: spend one per launch, regain one per returned pulse, saturate at max.
  always_comb begin
    credit_d   = credit_q;
    err_d      = err_q;
    out_data_d = out_data_q;
    if (send) begin
      out_data_d = fifo_head;
    end
    case ({send, credit_in_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CreditMax) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // Launch register, credit counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      credit_q    <= CreditMax;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= send;
      out_data_q  <= out_data_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_data_o       = out_data_q;
  assign credit_cnt_o     = credit_q;
  assign err_credit_ovf_o = err_q;

endmodule

// File: tb/tb_sbox_link_tx.sv
// Directed and randomized checks of sbox_link_tx against a queue-based reference model.
module tb_sbox_link_tx;

  localparam int unsigned W       = 32;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned CREDITS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        credit_in = 1'b0;
  logic [1:0]  credit_cnt;
  logic        err_credit_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] mq[$];
  int          m_cred = CREDITS;
  bit          m_err  = 1'b0;
  bit          m_outv = 1'b0;
  logic [31:0] m_outd = '0;

  always #5 clk = ~clk;

  sbox_link_tx #(
    .W       (W),
    .DEPTH   (DEPTH),
    .CREDITS (CREDITS)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid_i       (in_valid),
    .in_data_i        (in_data),
    .in_ready_o       (in_ready),
    .out_valid_o      (out_valid),
    .out_data_o       (out_data),
    .credit_in_i      (credit_in),
    .credit_cnt_o     (credit_cnt),
    .err_credit_ovf_o (err_credit_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model over the edge, then compare every output.
  task automatic step(input bit v, input logic [31:0] d, input bit c, input bit r);
    bit psh;
    bit snd;
    in_valid  = v;
    in_data   = d;
    credit_in = c;
    reset     = r;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_cred = CREDITS;
      m_err  = 1'b0;
      m_outv = 1'b0;
      m_outd = '0;
    end else begin
      psh    = v && (mq.size() < DEPTH);
      snd    = (mq.size() > 0) && (m_cred > 0);
      m_outv = snd;
      if (snd) m_outd = mq.pop_front();
      if (psh) mq.push_back(d);
      m_cred = m_cred - int'(snd) + int'(c);
      if (m_cred > CREDITS) begin
        m_cred = CREDITS;
        m_err  = 1'b1;
      end
    end
    #1;
    chk("in_ready",   32'(in_ready),       32'(mq.size() < DEPTH));
    chk("out_valid",  32'(out_valid),      32'(m_outv));
    chk("out_data",   out_data,            m_outd);
    chk("credit_cnt", 32'(credit_cnt),     32'(m_cred));
    chk("err_ovf",    32'(err_credit_ovf), 32'(m_err));
  endtask

  initial begin
    // Reset then a single word
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_credit", 32'(credit_cnt), 32'd2);
    chk("rst_ready", 32'(in_ready), 32'd1);
    step(1, 32'hDEADBEEF, 0, 0);
    chk("single_not_yet", 32'(out_valid), 32'd0);
    step(0, 0, 0, 0);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_data", out_data, 32'hDEADBEEF);
    chk("single_credit", 32'(credit_cnt), 32'd1);

    // Credit exhaustion
    step(0, 0, 0, 1);
    step(1, 32'h1, 0, 0);
    step(1, 32'h2, 0, 0);
    chk("exh_w1", out_data, 32'h1);
    step(1, 32'h3, 0, 0);
    chk("exh_w2", out_data, 32'h2);
    step(0, 0, 0, 0);
    chk("exh_stall_valid", 32'(out_valid), 32'd0);
    chk("exh_zero_credit", 32'(credit_cnt), 32'd0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("exh_w3_valid", 32'(out_valid), 32'd1);
    chk("exh_w3", out_data, 32'h3);
    chk("exh_credit_after", 32'(credit_cnt), 32'd0);

    // FIFO full with no credits: only four of six words accepted
    for (int i = 0; i < 6; i++) step(1, 32'hA0 + 32'(i), 0, 0);
    chk("full_ready_low", 32'(in_ready), 32'd0);
    step(0, 0, 1, 0);
    // Simultaneous send and credit return keeps the count at one
    step(0, 0, 1, 0);
    chk("simul_valid", 32'(out_valid), 32'd1);
    chk("simul_w0", out_data, 32'hA0);
    chk("simul_credit", 32'(credit_cnt), 32'd1);
    step(0, 0, 1, 0);
    chk("simul_w1", out_data, 32'hA1);
    step(0, 0, 1, 0);
    chk("drain_w2", out_data, 32'hA2);
    step(0, 0, 0, 0);
    chk("drain_w3", out_data, 32'hA3);
    step(0, 0, 0, 0);
    chk("drain_done", 32'(out_valid), 32'd0);

    // Credit overflow is sticky until reset
    step(0, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("ovf_credit", 32'(credit_cnt), 32'd2);
    chk("ovf_flag", 32'(err_credit_ovf), 32'd1);
    step(0, 0, 0, 0);
    chk("ovf_held", 32'(err_credit_ovf), 32'd1);
    step(0, 0, 0, 1);
    chk("ovf_cleared", 32'(err_credit_ovf), 32'd0);

    // Reset mid-stream with three words buffered and one credit
    for (int i = 0; i < 5; i++) step(1, 32'hB0 + 32'(i), 0, 0);
    step(0, 0, 1, 0);
    chk("mid_credit_pre", 32'(credit_cnt), 32'd1);
    step(0, 0, 0, 1);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_credit", 32'(credit_cnt), 32'd2);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    chk("mid_no_stale", 32'(out_valid), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(99) < 60, $urandom, $urandom_range(99) < 35,
           $urandom_range(99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sbox_link_tx.md
Name: sbox_link_tx

Overview:
- Credit-based transmitter that drives one 32-bit input side (north/west/south/east) of a switch box from a producing compute unit.
- Accepts words from the producer through a valid/ready handshake and buffers them in a small FIFO.
- Launches words toward the switch box only while it holds downstream credits. The switch-box side returns one credit pulse per word it consumes.
- One instance is placed per sbox input that a compute unit feeds.

Parameters:
- W, 32: data word width; must match the sbox port width.
- DEPTH, 4: FIFO entries (power of two, >= 2).
- CREDITS, 2: initial and maximum downstream credits (>= 1); equals the sbox input buffer depth.

Ports:
- clk, input, 1: single clock; all logic is rising-edge.
- reset, input, 1: synchronous, active-high reset.
- in_valid, input, 1: producer word valid.
- in_data, input, W: producer word.
- in_ready, output, 1: FIFO can accept a word this cycle.
- out_valid, output, 1: word launched to the sbox port this cycle (registered).
- out_data, output, W: word toward the sbox input (registered).
- credit_in, input, 1: single-cycle pulse; one sbox buffer slot freed.
- credit_cnt, output, $clog2(CREDITS+1): current credit count.
- err_credit_ovf, output, 1: sticky flag; a credit was returned while the count was already CREDITS.

Behaviour:
- Interface decision, fixed: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - FIFO empty; in_ready=1 from the first cycle after reset.
  - out_valid=0, out_data=0.
  - credit_cnt=CREDITS.
  - err_credit_ovf=0.
- Reset mid-operation: any reset-high edge discards all buffered words and any launch in flight, and restores all reset values. The block does not emit a partial flush.
- Push:
  - Occurs when in_valid && in_ready at a rising edge.
  - in_ready = (fifo_count < DEPTH), driven combinationally from the registered count only. It has no dependency on in_valid or on a same-cycle pop, so there is no push while full.
- Launch condition: at each edge, send = (fifo_count > 0) && (credit_cnt > 0).
- Launch registers:
  - out_valid <= send.
  - out_data <= FIFO head when send; otherwise hold the previous value.
  - The head is popped on the same edge.
- Latency: a word pushed at edge k appears with out_valid=1 in the cycle after edge k+1, provided the FIFO was empty and credits > 0. There is no push-to-output bypass.
- Back-to-back: one word per cycle sustained while the FIFO is non-empty and credits remain. out_valid drops for exactly the cycles in which send=0.
- Credit update: credit_cnt_next = credit_cnt - send + credit_in.
  - send and credit_in in the same cycle leaves the count unchanged.
  - credit_in with credit_cnt==CREDITS and !send: the count stays at CREDITS (saturate) and err_credit_ovf is set; it is cleared only by reset.
  - The count can never go negative, because send requires credit_cnt > 0.
- Push and pop on the same edge leave fifo_count unchanged. A push into an empty FIFO cannot be popped on the same edge, because send uses the pre-edge count.
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally. Count is $clog2(DEPTH)+1 bits.
- Ordering: strict FIFO order; no reordering or drops.

Decomposition:
- Shared package sbox_pkg:
  - Constant W=32.
  - Direction enum {NORTH, WEST, SOUTH, EAST}, used for instance labelling.
  - Credit-count width function.
- One natural sub-module: sync_fifo (W, DEPTH). Provides push/pop, head data, count, full/empty, and synchronous active-high reset. The credit counter and launch register stay in sbox_link_tx.

Test Plan:
- Reset then single word: hold reset 2 cycles; push 0xDEADBEEF at edge 3.
  - Required: out_valid=1 with out_data=0xDEADBEEF in the cycle after edge 4.
  - Required: credit_cnt steps 2->1.
- Credit exhaustion: push 0x1,0x2,0x3 back-to-back with no credit_in.
  - Required: 0x1 and 0x2 launch on consecutive cycles, then credit_cnt=0 and out_valid stays 0.
  - Then pulse credit_in once: required 0x3 launches on the next edge, and credit_cnt remains 0 afterward.
- FIFO full: with credits 0, push 6 words.
  - Required: in_ready falls after 4 accepted words; words 5 and 6 are held off.
  - After credit returns, the 4 accepted words exit in order.
- Simultaneous send and credit: with credit_cnt=1 and the FIFO non-empty, assert credit_in in the send cycle.
  - Required: credit_cnt stays 1 and launch continues next cycle.
- Credit overflow: idle with credit_cnt=2, pulse credit_in.
  - Required: credit_cnt=2 and err_credit_ovf=1 held.
  - A reset pulse then clears it to 0.
- Reset mid-stream: assert reset with 3 words buffered and credits=1.
  - Required next cycle: out_valid=0, in_ready=1, credit_cnt=2.
  - No stale words are launched afterward.
